mant_norm16: RTL and testbench
==============================

MANT_NORM16 -- requirements
Module: mant_norm16

Interface
REQ-001 Parameter: EXP_W, 8, exponent width in bits (legal 5..16).
REQ-002 clk  input  1  rising-edge clock; all state updates on posedge clk.
REQ-003 rst  input  1  synchronous, active-high reset, sampled on posedge clk.
REQ-004 in_valid  input  1  upstream offers an operand this cycle.
REQ-005 in_ready  output  1  block accepts the operand this cycle.
REQ-006 mant_in  input  [0:15]  unnormalized mantissa; bit 0 is MSB.
REQ-007 exp_in  input  EXP_W  unsigned biased exponent of mant_in.
REQ-008 out_valid  output  1  normalized result available.
REQ-009 out_ready  input  1  downstream accepts the result this cycle.
REQ-010 mant_out  output  [0:15]  normalized mantissa; bit 0 is MSB.
REQ-011 exp_out  output  EXP_W  adjusted exponent.
REQ-012 zero  output  1  mant_in was all zeros.
REQ-013 uflow  output  1  leading-zero count exceeded exp_in; result is denormal.

Function
REQ-014 A transfer occurs on a posedge where valid and ready are both 1, on each side independently.
REQ-015 Two-stage pipeline: S1 registers mant_in, exp_in, lzc and shift amount; S2 registers the shifted result and flags; latency from input transfer to out_valid is exactly 2 cycles.
REQ-016 lzc = number of leading zeros of mant_in counted from bit 0, range 0..15 for a non-zero input.
REQ-017 Shift amount shamt (4 bits) = min(lzc, exp_in); uflow = 1 when lzc > exp_in, else 0.
REQ-018 mant_out[i] = mant_in[i+shamt] for i+shamt <= 15, else 0 (left shift, zero fill at bit 15 end).
REQ-019 exp_out = exp_in - shamt; it never wraps below 0.
REQ-020 Zero input: zero = 1, mant_out = 0, exp_out = 0, uflow = 0, shamt = 0.
REQ-021 Already-normalized input (mant_in[0] = 1): mant_out = mant_in, exp_out = exp_in, flags 0.
REQ-022 S2 may load when out_valid = 0 or out_ready = 1 (s2_free); S1 may load when S1 is empty or S1 advances into S2 in the same cycle.
REQ-023 in_ready = !s1_valid | s2_free; this is combinational, with no dependence on in_valid, so back-to-back operands sustain one result per cycle.
REQ-024 While out_valid = 1 and out_ready = 0, mant_out, exp_out, zero and uflow hold stable; no result is dropped or duplicated.
REQ-025 Under full stall, both stages hold, in_ready = 0, and the pipeline holds at most 2 results.
REQ-026 Result order equals input order.
REQ-027 The outputs of a pipeline stage are undefined when its valid is 0; the bench checks data only when out_valid = 1.

Reset
REQ-028 When rst = 1 at a posedge, s1_valid = 0, out_valid = 0, mant_out = 0, exp_out = 0, zero = 0 and uflow = 0 on the next cycle.
REQ-029 Reset mid-operation discards all in-flight results; no result issues after reset is deasserted unless a new input transfer occurs.
REQ-030 in_ready = 1 in the first cycle after reset is released.

Structure
REQ-031 A shared package fp_alu_pkg holds MANT_W = 16, SHAMT_W = 4 and the default EXP_W.
REQ-032 The left shifter is built from 16 instances of the existing mux_16to1, with port order (out, in[0:15], sel[0:3]) and out = in[sel]. Instance i is wired to in = {mant[i..15], zeros} and sel = shamt.
REQ-033 The leading-zero counter is combinational logic within mant_norm16; there is no further sub-module.

Verification
REQ-034 mant_in = 16'h8000, exp_in = 8'd10 -> after 2 cycles: mant_out = 16'h8000, exp_out = 10, zero = 0, uflow = 0.
REQ-035 mant_in = 16'h0001, exp_in = 8'd20 -> mant_out = 16'h8000, exp_out = 5, uflow = 0.
REQ-036 mant_in = 16'h0010, exp_in = 8'd3 -> lzc = 11, shamt = 3, mant_out = 16'h0080, exp_out = 0, uflow = 1.
REQ-037 mant_in = 16'h0000, exp_in = 8'd50 -> zero = 1, mant_out = 0, exp_out = 0, uflow = 0.
REQ-038 Stream 8 operands back-to-back, out_ready toggling 1,0,0,1,... -> all 8 results in order, none lost or duplicated, data stable during each stall, in_ready = 0 only when both stages are full.
REQ-039 Assert rst for 1 cycle while 2 results are in flight -> out_valid = 0 the next cycle, no stale result ever appears, in_ready = 1 once rst is deasserted.

Source files
------------

// File: rtl/fp_alu_pkg.sv
// Shared constants for the floating-point datapath blocks.
// The mantissa width is fixed at 16 bits, so a shift amount always fits in 4 bits.
package fp_alu_pkg;

  localparam int MANT_W        = 16;
  localparam int SHAMT_W       = 4;
  localparam int EXP_W_DEFAULT = 8;
  // One extra bit so an all-zero mantissa can report a count of 16.
  localparam int LZC_W         = SHAMT_W + 1;

endpackage

// File: rtl/mux_16to1.sv
// Plain 16:1 bit multiplexer; bit 0 of each vector is the MSB.
module mux_16to1 (
  output logic        out,
  input  logic [0:15] in,
  input  logic [0:3]  sel
);

  assign out = in[sel];

endmodule

// File: rtl/mant_norm16.sv
// Two-stage mantissa normaliser: leading-zero count in S1, left shift and
// exponent adjust in S2, with a valid/ready handshake on both sides.
module mant_norm16
  import fp_alu_pkg::*;
#(
  parameter int EXP_W = EXP_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [0:MANT_W-1] mant_in,
  input  logic [EXP_W-1:0]  exp_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [0:MANT_W-1] mant_out,
  output logic [EXP_W-1:0]  exp_out,
  output logic              zero,
  output logic              uflow
);

  logic               in_zero;
  logic [LZC_W-1:0]   lzc;
  logic [SHAMT_W-1:0] shamt;

  logic               s1_valid;
  logic [0:MANT_W-1]  s1_mant;
  logic [EXP_W-1:0]   s1_exp;
  logic [LZC_W-1:0]   s1_lzc;
  logic [SHAMT_W-1:0] s1_shamt;

  logic               s2_free;
  logic               s1_zero;
  logic               s1_uflow;
  logic [EXP_W-1:0]   exp_adj;
  logic [0:MANT_W-1]  shifted;
  logic [0:MANT_W-1]  mux_in [MANT_W];

  assign in_zero = ~|mant_in;

  // NOTE: every variable gets a default before the loop, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    lzc = LZC_W'(MANT_W);
    for (int i = MANT_W - 1; i >= 0; i--) begin
      if (mant_in[i]) lzc = LZC_W'(i);
    end
  end

  // The shift stops at exponent zero; the remaining leading zeros become a denormal.
  always_comb begin
    shamt = '0;
    if (!in_zero) begin
      if (EXP_W'(lzc) > exp_in) shamt = exp_in[SHAMT_W-1:0];
      else                      shamt = lzc[SHAMT_W-1:0];
    end
  end

  assign s2_free  = !out_valid || out_ready;
  assign in_ready = !s1_valid || s2_free;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst)           s1_valid <= 1'b0;
    else if (in_ready) s1_valid <= in_valid;
  end

  // NOTE: payload registers carry no reset; they are qualified by s1_valid.
  always_ff @(posedge clk) begin
    if (in_valid && in_ready) begin
      s1_mant  <= mant_in;
      s1_exp   <= exp_in;
      s1_lzc   <= lzc;
      s1_shamt <= shamt;
    end
  end

  for (genvar i = 0; i < MANT_W; i++) begin : g_shift
    assign mux_in[i] = s1_mant << i;
    mux_16to1 u_mux (
      .out (shifted[i]),
      .in  (mux_in[i]),
      .sel (s1_shamt)
    );
  end

  assign s1_zero  = ~|s1_mant;
  assign s1_uflow = !s1_zero && (EXP_W'(s1_lzc) > s1_exp);
  assign exp_adj  = s1_zero ? '0 : s1_exp - EXP_W'(s1_shamt);

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      mant_out  <= '0;
      exp_out   <= '0;
      zero      <= 1'b0;
      uflow     <= 1'b0;
    end else if (s2_free) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        mant_out <= shifted;
        exp_out  <= exp_adj;
        zero     <= s1_zero;
        uflow    <= s1_uflow;
      end
    end
  end

endmodule

// File: tb/tb_mant_norm16.sv
// Randomised bench for mant_norm16 against an arithmetic reference model
// and an in-order scoreboard, plus directed corner cases and a mid-flight reset.
module tb_mant_norm16;
  import fp_alu_pkg::*;

  localparam int EXP_W = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [0:15]       mant_in;
  logic [EXP_W-1:0]  exp_in;
  logic              out_valid;
  logic              out_ready;
  logic [0:15]       mant_out;
  logic [EXP_W-1:0]  exp_out;
  logic              zero;
  logic              uflow;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic [15:0]      mant;
    logic [EXP_W-1:0] ex;
    logic             zero;
    logic             uflow;
    int               cyc;
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mant_norm16 #(.EXP_W(EXP_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mant_in   (mant_in),
    .exp_in    (exp_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .mant_out  (mant_out),
    .exp_out   (exp_out),
    .zero      (zero),
    .uflow     (uflow)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Normalisation from the arithmetic definition: count leading zeros, shift
  // left by at most the exponent, flag whatever could not be shifted out.
  function automatic exp_t model(input logic [15:0] m, input int e);
    exp_t r;
    int lz = 0;
    int sh;
    r.cyc = 0;
    if (m == 16'h0) begin
      r.mant = 16'h0; r.ex = '0; r.zero = 1'b1; r.uflow = 1'b0;
      return r;
    end
    while ((m >> (15 - lz)) == 16'h0) lz++;
    sh      = (lz < e) ? lz : e;
    r.mant  = m << sh;
    r.ex    = EXP_W'(e - sh);
    r.zero  = 1'b0;
    r.uflow = (lz > e);
    return r;
  endfunction

  logic             rst_prev   = 1'b0;
  logic             stall_prev = 1'b0;
  logic [15:0]      held_mant;
  logic [EXP_W-1:0] held_exp;
  logic             held_zero, held_uflow;

  always @(negedge clk) begin
    exp_t e;
    if (rst_prev) begin
      check("rst_out_valid", out_valid, 0);
      check("rst_mant_out",  mant_out,  0);
      check("rst_exp_out",   exp_out,   0);
      check("rst_zero",      zero,      0);
      check("rst_uflow",     uflow,     0);
      check("rst_in_ready",  in_ready,  1);
    end
    if (!rst) begin
      check("out_valid", out_valid, (q.size() > 0) && (cyc >= q[0].cyc + 2));
      check("in_ready",  in_ready,  !(q.size() == 2 && !out_ready));
      if (stall_prev) begin
        check("hold_mant",  mant_out, held_mant);
        check("hold_exp",   exp_out,  held_exp);
        check("hold_zero",  zero,     held_zero);
        check("hold_uflow", uflow,    held_uflow);
      end
      if (out_valid && q.size() > 0) begin
        check("mant_out", mant_out, q[0].mant);
        check("exp_out",  exp_out,  q[0].ex);
        check("zero",     zero,     q[0].zero);
        check("uflow",    uflow,    q[0].uflow);
        if (out_ready) void'(q.pop_front());
      end
      if (in_valid && in_ready) begin
        e = model(mant_in, int'(exp_in));
        e.cyc = cyc;
        q.push_back(e);
      end
      stall_prev = out_valid && !out_ready;
      held_mant  = mant_out;
      held_exp   = exp_out;
      held_zero  = zero;
      held_uflow = uflow;
    end else begin
      q.delete();
      stall_prev = 1'b0;
    end
    rst_prev = rst;
  end

  task automatic directed(input logic [15:0] m, input logic [EXP_W-1:0] e,
                          input logic [15:0] rm, input logic [EXP_W-1:0] re,
                          input logic rz, input logic ru);
    in_valid = 1'b1; mant_in = m; exp_in = e; out_ready = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("dir_valid", out_valid, 1);
    check("dir_mant",  mant_out,  rm);
    check("dir_exp",   exp_out,   re);
    check("dir_zero",  zero,      rz);
    check("dir_uflow", uflow,     ru);
    @(posedge clk); #1;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (q.size() != 0 && n < budget) begin
      @(posedge clk); #1 out_ready = 1'b1; n++;
    end
    check("drain_empty", q.size(), 0);
  endtask

  initial begin
    logic [15:0] r;
    logic [3:0]  pat;
    int          sent;
    int          k;
    logic        took;
    exp_t        p;

    rst = 1'b1; in_valid = 1'b0; mant_in = '0; exp_in = '0; out_ready = 1'b1;
    @(posedge clk); @(posedge clk); #1 rst = 1'b0;

    p = model(16'h8000, 10);
    check("pin_a_mant", p.mant, 16'h8000); check("pin_a_exp", p.ex, 10);
    p = model(16'h0001, 20);
    check("pin_b_mant", p.mant, 16'h8000); check("pin_b_exp", p.ex, 5);
    p = model(16'h0010, 3);
    check("pin_c_mant", p.mant, 16'h0080); check("pin_c_uflow", p.uflow, 1);
    p = model(16'h0000, 50);
    check("pin_d_zero", p.zero, 1); check("pin_d_exp", p.ex, 0);

    directed(16'h8000, 8'd10, 16'h8000, 8'd10, 1'b0, 1'b0);
    directed(16'h0001, 8'd20, 16'h8000, 8'd5,  1'b0, 1'b0);
    directed(16'h0010, 8'd3,  16'h0080, 8'd0,  1'b0, 1'b1);
    directed(16'h0000, 8'd50, 16'h0000, 8'd0,  1'b1, 1'b0);

    // Eight back-to-back operands with out_ready cycling 1,0,0,1.
    pat = 4'b1001;
    sent = 0; k = 0;
    while (sent < 8 && k < 200) begin
      r = 16'h4000 >> sent;
      in_valid = 1'b1; mant_in = r | 16'(sent); exp_in = EXP_W'(4 + sent);
      out_ready = pat[3 - (k % 4)];
      @(negedge clk); took = in_ready;
      @(posedge clk); #1;
      if (took) sent++;
      k++;
    end
    check("stream_sent", sent, 8);
    in_valid = 1'b0;
    while (q.size() != 0 && k < 400) begin
      out_ready = pat[3 - (k % 4)];
      @(posedge clk); #1; k++;
    end
    drain(50);

    for (int i = 0; i < 600; i++) begin
      r = 16'($urandom());
      in_valid  = ($urandom_range(0, 99) < 70);
      out_ready = ($urandom_range(0, 99) < 60);
      mant_in   = r >> $urandom_range(0, 16);
      exp_in    = ($urandom_range(0, 3) == 0) ? EXP_W'($urandom()) : EXP_W'($urandom_range(0, 20));
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    drain(50);

    // Two results in flight, then a one-cycle reset.
    out_ready = 1'b0;
    in_valid = 1'b1; mant_in = 16'h0123; exp_in = 8'd9;
    @(posedge clk); #1 mant_in = 16'h00F0; exp_in = 8'd2;
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    check("flight_count", q.size(), 2);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0; out_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    directed(16'h0100, 8'd30, 16'h8000, 8'd23, 1'b0, 1'b0);
    drain(20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
